// File: rtl/retro_memory_pkg.sv
// Shared types for the retro memory arbiter: requester index and tag FIFO
// occupancy, sized for the default configuration.
package retro_memory_pkg;

  localparam int DefaultInitiators  = 2;
  localparam int DefaultOutstanding = 4;

  // Identifies one requester; also the payload of the read tag FIFO.
  typedef logic [$clog2(DefaultInitiators)-1:0] req_idx_t;

  // Number of reads in flight, 0..DefaultOutstanding inclusive.
  typedef logic [$clog2(DefaultOutstanding):0] occ_count_t;

endpackage

// File: rtl/retro_tag_fifo.sv
// Tag FIFO remembering which requester owns each outstanding read.
// Push and pop may occur together in any state, including full.
module retro_tag_fifo #(
  parameter int Depth = 4,
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (PtrW+1)'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Tag storage written at the write pointer.
  // NOTE: storage is not reset; an entry is only read after it has been
  // written, so clearing it would only cost flops and reset routing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because Depth is a power of two.
  // NOTE: all clocked state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/retro_memory_arbiter.sv
// Round-robin arbiter sharing one memory target among several requesters,
// with zero-latency accept and in-order read response routing by tag.
module retro_memory_arbiter
  import retro_memory_pkg::*;
#(
  parameter int NumInitiators   = DefaultInitiators,
  parameter int AddressBusWidth = 16,
  parameter int DataBusWidth    = 1,
  parameter int MaxOutstanding  = DefaultOutstanding
) (
  input  logic                                   Clk,
  input  logic                                   Reset_n,
  input  logic [NumInitiators*AddressBusWidth-1:0] ReqAddress,
  input  logic [NumInitiators*8*DataBusWidth-1:0]  ReqDout,
  input  logic [NumInitiators*8*DataBusWidth-1:0]  ReqAccess,
  input  logic [NumInitiators-1:0]               ReqWrite,
  output logic [NumInitiators-1:0]               ReqReady,
  output logic [NumInitiators-1:0]               ReqDataReady,
  output logic [8*DataBusWidth-1:0]              ReqDin,
  output logic [AddressBusWidth-1:0]             MemAddress,
  output logic [8*DataBusWidth-1:0]              MemDout,
  output logic [8*DataBusWidth-1:0]              MemAccess,
  output logic                                   MemWrite,
  input  logic                                   MemReady,
  input  logic                                   MemDataReady,
  input  logic [8*DataBusWidth-1:0]              MemDin,
  output logic                                   ProtocolError
);

  localparam int IdxW  = $clog2(NumInitiators);
  localparam int ByteW = 8 * DataBusWidth;

  typedef logic [IdxW-1:0] idx_t;

  idx_t                     ptr;
  idx_t                     sel_idx;
  idx_t                     head;
  logic                     sel_valid;
  logic                     sel_write;
  logic                     grant;
  logic                     pop;
  logic                     push;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [NumInitiators-1:0] requesting;
  logic [ByteW-1:0]         sel_access;

  // A requester wants the bus when any of its access mask bits is set.
  always_comb begin
    for (int i = 0; i < NumInitiators; i++) begin
      requesting[i] = |ReqAccess[i*ByteW +: ByteW];
    end
  end

  // Round-robin search upward from ptr, wrapping at NumInitiators.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    int j;
    sel_valid = 1'b0;
    sel_idx   = '0;
    j         = 0;
    for (int k = 0; k < NumInitiators; k++) begin
      j = int'(ptr) + k;
      if (j >= NumInitiators) j = j - NumInitiators;
      if (!sel_valid && requesting[j]) begin
        sel_valid = 1'b1;
        sel_idx   = idx_t'(j);
      end
    end
  end

  assign sel_write  = ReqWrite[sel_idx];
  assign sel_access = ReqAccess[int'(sel_idx)*ByteW +: ByteW];
  assign pop        = MemDataReady && !fifo_empty;
  // A read may take the slot a same-cycle response frees; reset blocks all grants.
  assign grant      = Reset_n && sel_valid && MemReady &&
                      (sel_write || !fifo_full || pop);
  assign push       = grant && !sel_write;

  assign MemAddress = ReqAddress[int'(sel_idx)*AddressBusWidth +: AddressBusWidth];
  assign MemDout    = ReqDout[int'(sel_idx)*ByteW +: ByteW];
  assign MemAccess  = grant ? sel_access : '0;
  assign MemWrite   = sel_write;
  assign ReqDin     = MemDin;

  // One-hot accept and read-data strobes for the granted and head requesters.
  always_comb begin
    ReqReady     = '0;
    ReqDataReady = '0;
    if (grant) ReqReady[sel_idx]  = 1'b1;
    if (pop)   ReqDataReady[head] = 1'b1;
  end

  // Priority moves just past the last accepted requester.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (sel_idx == idx_t'(NumInitiators - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  // Sticky flag for a response that has no outstanding read to own it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ProtocolError <= 1'b0;
    end else if (MemDataReady && fifo_empty) begin
      ProtocolError <= 1'b1;
    end
  end

  retro_tag_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_tag_fifo (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .push      (push),
    .push_data (sel_idx),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_retro_memory_arbiter.sv
// Self-checking bench for retro_memory_arbiter (default parameters).
// Inputs change just after the falling edge and outputs are sampled 1ns
// later; a scoreboard queue holds the requester expected for each read.
module tb_retro_memory_arbiter;
  import retro_memory_pkg::*;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MO = 4;

  logic            Clk = 1'b0;
  logic            Reset_n;
  logic [N*AW-1:0] ReqAddress;
  logic [N*DW-1:0] ReqDout;
  logic [N*DW-1:0] ReqAccess;
  logic [N-1:0]    ReqWrite;
  logic [N-1:0]    ReqReady;
  logic [N-1:0]    ReqDataReady;
  logic [DW-1:0]   ReqDin;
  logic [AW-1:0]   MemAddress;
  logic [DW-1:0]   MemDout;
  logic [DW-1:0]   MemAccess;
  logic            MemWrite;
  logic            MemReady;
  logic            MemDataReady;
  logic [DW-1:0]   MemDin;
  logic            ProtocolError;

  retro_memory_arbiter #(
    .NumInitiators   (N),
    .AddressBusWidth (AW),
    .DataBusWidth    (1),
    .MaxOutstanding  (MO)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .ReqAddress    (ReqAddress),
    .ReqDout       (ReqDout),
    .ReqAccess     (ReqAccess),
    .ReqWrite      (ReqWrite),
    .ReqReady      (ReqReady),
    .ReqDataReady  (ReqDataReady),
    .ReqDin        (ReqDin),
    .MemAddress    (MemAddress),
    .MemDout       (MemDout),
    .MemAccess     (MemAccess),
    .MemWrite      (MemWrite),
    .MemReady      (MemReady),
    .MemDataReady  (MemDataReady),
    .MemDin        (MemDin),
    .ProtocolError (ProtocolError)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  req_idx_t exp_tags[$];
  int       m_ptr;
  logic     m_err;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock: drive inputs, compare outputs with the reference model,
  // then advance the model as the coming rising edge will.
  task automatic cycle(input string tag, input logic rst, input logic [N-1:0] active,
                       input logic [N-1:0] wr, input logic mr, input logic dr,
                       input logic [DW-1:0] din);
    bit   found;
    int   gidx;
    bit   exp_grant;
    bit   had_tags;
    req_idx_t t;
    @(negedge Clk);
    Reset_n = rst;
    for (int i = 0; i < N; i++) begin
      ReqAddress[i*AW +: AW] = 16'(32'h1000 + i);
      ReqDout[i*DW +: DW]    = 8'(32'h50 + i);
      ReqAccess[i*DW +: DW]  = active[i] ? 8'hFF : 8'h00;
    end
    ReqWrite     = wr;
    MemReady     = mr;
    MemDataReady = dr;
    MemDin       = din;
    if (!rst) begin
      m_ptr = 0;
      m_err = 1'b0;
      exp_tags.delete();
    end
    #1;
    found = 1'b0;
    gidx  = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (!found && active[j]) begin
        found = 1'b1;
        gidx  = j;
      end
    end
    had_tags  = exp_tags.size() > 0;
    exp_grant = rst && found && mr &&
                (wr[gidx] || exp_tags.size() < MO || (dr && had_tags));
    check({tag, ".ready"}, 32'(ReqReady), exp_grant ? (32'd1 << gidx) : 32'd0);
    check({tag, ".access"}, 32'(MemAccess), exp_grant ? 32'hFF : 32'h0);
    if (exp_grant) begin
      check({tag, ".addr"}, 32'(MemAddress), 32'h1000 + gidx);
      check({tag, ".wdata"}, 32'(MemDout), 32'h50 + gidx);
      check({tag, ".write"}, 32'(MemWrite), 32'(wr[gidx]));
    end
    if (rst && dr && had_tags) begin
      t = exp_tags.pop_front();
      check({tag, ".dready"}, 32'(ReqDataReady), 32'd1 << t);
      check({tag, ".rdata"}, 32'(ReqDin), 32'(din));
    end else begin
      check({tag, ".dready"}, 32'(ReqDataReady), 32'd0);
    end
    check({tag, ".perr"}, 32'(ProtocolError), 32'(m_err));
    if (rst) begin
      if (dr && !had_tags) m_err = 1'b1;
      if (exp_grant) begin
        m_ptr = (gidx + 1) % N;
        if (!wr[gidx]) exp_tags.push_back(req_idx_t'(gidx));
      end
    end
  endtask

  initial begin
    Reset_n      = 1'b0;
    ReqAddress   = '0;
    ReqDout      = '0;
    ReqAccess    = '0;
    ReqWrite     = '0;
    MemReady     = 1'b0;
    MemDataReady = 1'b0;
    MemDin       = '0;
    m_ptr        = 0;
    m_err        = 1'b0;

    // Reset holds everything quiet even with all requests and MemReady up.
    cycle("rst0", 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    cycle("rst1", 1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    check("rst_ready_const", 32'(ReqReady), 32'h0);
    check("rst_access_const", 32'(MemAccess), 32'h0);

    // Release: requester 0 wins first, then grants alternate and fill the FIFO.
    cycle("rr0", 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    check("rr0_const", 32'(ReqReady), 32'h1);
    cycle("rr1", 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    check("rr1_const", 32'(ReqReady), 32'h2);
    cycle("rr2", 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    check("rr2_const", 32'(ReqReady), 32'h1);
    cycle("rr3", 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    check("rr3_const", 32'(ReqReady), 32'h2);

    // Full: fifth read stalls, a write still goes, a response lets the read in.
    cycle("full_stall", 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    check("full_stall_const", 32'(ReqReady), 32'h0);
    cycle("full_write", 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 8'h00);
    check("full_write_const", 32'(ReqReady), 32'h2);
    cycle("full_swap", 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 8'h11);
    check("full_swap_ready", 32'(ReqReady), 32'h1);
    check("full_swap_dready", 32'(ReqDataReady), 32'h1);
    cycle("drain0", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'h22);
    cycle("drain1", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'h33);
    cycle("drain2", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'h44);
    cycle("drain3", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'h55);

    // Routing: read from 1 then 0; responses return in that order.
    cycle("route_rd1", 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 8'h00);
    cycle("route_rd0", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 8'h00);
    cycle("route_a5", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'hA5);
    check("route_a5_const", {24'h0, 6'h0, ReqDataReady}, 32'h2);
    check("route_a5_data", 32'(ReqDin), 32'hA5);
    cycle("route_3c", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'h3C);
    check("route_3c_const", {24'h0, 6'h0, ReqDataReady}, 32'h1);
    check("route_3c_data", 32'(ReqDin), 32'h3C);

    // Backpressure: no grant while MemReady is low, priority pointer frozen at 1.
    for (int i = 0; i < 3; i++) begin
      cycle("bp_wait", 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 8'h00);
      check("bp_wait_const", 32'(MemAccess), 32'h0);
    end
    cycle("bp_go", 1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 8'h00);
    check("bp_go_const", 32'(ReqReady), 32'h2);
    cycle("bp_resp", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'h77);

    // Stray response sets the sticky error until reset.
    cycle("err_pulse", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'hEE);
    check("err_no_dready", 32'(ReqDataReady), 32'h0);
    cycle("err_hold0", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00);
    check("err_set_const", 32'(ProtocolError), 32'h1);
    cycle("err_hold1", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00);
    cycle("err_rst", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00);
    check("err_clear_const", 32'(ProtocolError), 32'h0);

    // Outstanding read lost across reset: its late response is a protocol error.
    cycle("lost_rel", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 8'h00);
    cycle("lost_rst", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00);
    cycle("lost_rel2", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00);
    cycle("lost_resp", 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 8'h99);
    cycle("lost_flag", 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 8'h00);
    check("lost_flag_const", 32'(ProtocolError), 32'h1);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'b1, N'($urandom_range(0, 3)), N'($urandom_range(0, 3)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/retro_memory_arbiter.md
RETRO_MEMORY_ARBITER -- requirements
Module: retro_memory_arbiter

Interface
REQ-001 SHALL have parameter NumInitiators, default 2, number of requesters sharing one memory target (2..8).
REQ-002 SHALL have parameter AddressBusWidth, default 16, address width in bits.
REQ-003 SHALL have parameter DataBusWidth, default 1, data width in bytes.
REQ-004 SHALL have parameter MaxOutstanding, default 4, maximum reads in flight (power of two, 2..16).
REQ-005 SHALL have port: Clk  in  1  the single clock.
REQ-006 SHALL have port: Reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port: ReqAddress  in  NumInitiators*AddressBusWidth  per-requester address.
REQ-008 SHALL have port: ReqDout  in  NumInitiators*8*DataBusWidth  per-requester write data.
REQ-009 SHALL have port: ReqAccess  in  NumInitiators*8*DataBusWidth  per-requester access mask; a command is requested when any bit is set.
REQ-010 SHALL have port: ReqWrite  in  NumInitiators  per-requester write (1) or read (0).
REQ-011 SHALL have port: ReqReady  out  NumInitiators  command accepted this cycle.
REQ-012 SHALL have port: ReqDataReady  out  NumInitiators  read data valid for this requester.
REQ-013 SHALL have port: ReqDin  out  8*DataBusWidth  read data, broadcast to all requesters.
REQ-014 SHALL have ports: MemAddress  out  AddressBusWidth; MemDout  out  8*DataBusWidth; MemAccess  out  8*DataBusWidth; MemWrite  out  1 (target command side).
REQ-015 SHALL have ports: MemReady  in  1; MemDataReady  in  1; MemDin  in  8*DataBusWidth (target response side).
REQ-016 SHALL have port: ProtocolError  out  1  sticky flag, MemDataReady seen with no read outstanding.

Function
REQ-017 SHALL select each cycle one requesting index by round-robin, searching upward (with wrap) from priority pointer Ptr.
REQ-018 SHALL grant the selected index only if MemReady=1 and, for a read, the tag FIFO is not full or a pop occurs the same cycle.
REQ-019 SHALL drive Mem* combinationally from the granted requester; with no grant MemAccess SHALL be 0 and other Mem* outputs are don't-care.
REQ-020 SHALL assert ReqReady only for the granted index, in the same cycle (zero-latency accept).
REQ-021 SHALL, on accept of index i, load Ptr with (i+1) mod NumInitiators on the next edge; Ptr SHALL hold when no accept occurs.
REQ-022 SHALL push index i into the tag FIFO on each accepted read; writes SHALL NOT push.
REQ-023 SHALL, on MemDataReady=1 with the FIFO non-empty, pop the head and assert ReqDataReady[head] with ReqDin=MemDin in that same cycle.
REQ-024 SHALL, on MemDataReady=1 with the FIFO empty, discard the data, assert no ReqDataReady, and set ProtocolError until reset.
REQ-025 SHALL support push and pop in the same cycle, occupancy unchanged, including when full.
REQ-026 SHALL maintain occupancy 0..MaxOutstanding with wrap-around read and write pointers; it SHALL never exceed MaxOutstanding.
REQ-027 SHALL stall any read while the FIFO is full with no pop; writes by the same or other requesters SHALL still be granted.

Reset
REQ-028 SHALL, while Reset_n=0, hold Ptr=0, FIFO empty, ProtocolError=0, ReqReady=0, ReqDataReady=0, MemAccess=0.
REQ-029 SHALL discard outstanding read tags on reset mid-operation; responses arriving after release with an empty FIFO follow REQ-024.

Structure
REQ-030 SHALL place the requester-index typedef (width clog2(NumInitiators)) and the occupancy-count typedef in shared package retro_memory_pkg.
REQ-031 SHALL implement the tag FIFO as sub-module retro_tag_fifo (push, pop, full, empty, head), asynchronous active-low reset.

Verification
REQ-032 Reset: Reset_n=0 with all ReqAccess=0xFF, MemReady=1 -> MemAccess=0, ReqReady=00; after release -> ReqReady=01 (Ptr=0).
REQ-033 Round-robin: N=2, both read continuously, MemReady=1 -> grants alternate 0,1,0,1; FIFO holds 0,1,0,1.
REQ-034 Routing: reads from 1 then 0, then two MemDataReady pulses with MemDin=0xA5, 0x3C -> ReqDataReady=10 with 0xA5, then 01 with 0x3C.
REQ-035 Full: 4 reads accepted, no responses -> 5th read stalls with ReqReady=0; a write from requester 1 is still granted; MemDataReady pulse -> stalled read accepted that same cycle.
REQ-036 Backpressure: MemReady=0 for 3 cycles with requester 0 requesting -> ReqReady=0, MemAccess=0, Ptr unchanged; granted on the first cycle MemReady=1.
REQ-037 Error: MemDataReady=1 with FIFO empty -> no ReqDataReady, ProtocolError=1 held until Reset_n=0.
